// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: owns the byte-wide RAM port and shares it between
// instruction fetch and the LSU. Each grant is sequenced as 1/2/4 byte
// cycles. Reads account for the 1-cycle RAM latency. Writes to the IO region
// stall while the UART buffer is full.
// Optional build macro: RAM_ARB_AGING_EN adds a fetch age counter. A fetch
// that keeps losing to the LSU is forced to win after AGE_LIMIT losses.
module ram_port_arbiter #(
   parameter int         ADDR_W    = 32,
   parameter int         AGE_LIMIT = 8,
   parameter logic [1:0] IO_HI     = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic              if_done_out,
   output logic [31:0]       if_data_out,
   input  logic              flush_in,
   input  logic              ls_req_in,
   input  logic              ls_wr_in,
   input  logic [1:0]        ls_size_in,
   input  logic [ADDR_W-1:0] ls_addr_in,
   input  logic [31:0]       ls_wdata_in,
   output logic              ls_done_out,
   output logic [31:0]       ls_rdata_out,
   input  logic              io_buffer_full,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   output logic              busy_out
);

   typedef enum logic [2:0] {IDLE, FETCH, LSU_RD, LSU_WR, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;      // latched base address of the granted access
   logic [2:0]        len;       // transfer length in bytes (1, 2 or 4)
   logic [2:0]        n;         // byte cycle index within the transfer
   logic [3:0][7:0]   wbytes;    // latched store data, byte 0 = bits 7:0
   logic [3:0][7:0]   cap;       // read bytes captured so far
   logic [3:0][7:0]   cap_next;  // cap with this cycle's mem_din merged in
   logic [ADDR_W-1:0] cur_a;
   logic [2:0]        ls_len;
   logic              io_stall;
   logic              age_win;
   logic              if_ok;
   logic              ls_grant;
   logic              if_grant;

   // Size decode; 2'b11 is treated as a word.
   always_comb begin
      case (ls_size_in)
         2'b00:   ls_len = 3'd1;
         2'b01:   ls_len = 3'd2;
         default: ls_len = 3'd4;
      endcase
   end

   // Byte address for this cycle; plain wrap-around add, no alignment rules.
   assign cur_a    = addr + ADDR_W'(n);
   assign io_stall = (cur_a[17:16] == IO_HI) && io_buffer_full;

   // A fetch request seen together with a flush is stale and is not granted.
   assign if_ok    = if_req_in && !flush_in;
   assign ls_grant = (state == IDLE) && ls_req_in && !(age_win && if_ok);
   assign if_grant = (state == IDLE) && if_ok && !ls_grant;
   assign busy_out = (state != IDLE);

   // The byte requested in the previous cycle arrives on mem_din now.
   always_comb begin
      cap_next = cap;
      if (n != 3'd0) cap_next[2'(n - 3'd1)] = mem_din;
   end

   // RAM port drive. The port is idle (all zero) outside transfer byte cycles.
   // The address stays put during a freeze because it only depends on state.
   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      case (state)
         FETCH, LSU_RD: begin
            if (n < len) mem_a = cur_a;
         end
         LSU_WR: begin
            mem_a    = cur_a;
            mem_dout = wbytes[n[1:0]];
            mem_wr   = rdy_in && !io_stall;
         end
         default: ;
      endcase
   end

   // Arbitration and byte sequencing FSM with registered done/data outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state        <= IDLE;
         addr         <= '0;
         len          <= '0;
         n            <= '0;
         wbytes       <= '0;
         cap          <= '0;
         if_done_out  <= 1'b0;
         ls_done_out  <= 1'b0;
         if_data_out  <= '0;
         ls_rdata_out <= '0;
      end else if (rdy_in) begin
         if_done_out <= 1'b0;
         ls_done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (ls_grant) begin
                  addr   <= ls_addr_in;
                  len    <= ls_len;
                  wbytes <= ls_wdata_in;
                  n      <= '0;
                  cap    <= '0;
                  state  <= ls_wr_in ? LSU_WR : LSU_RD;
               end else if (if_grant) begin
                  addr  <= if_addr_in;
                  len   <= 3'd4;
                  n     <= '0;
                  cap   <= '0;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (flush_in) begin
                  // Mispredict: drop partial instruction, no done pulse.
                  n     <= '0;
                  state <= IDLE;
               end else begin
                  cap <= cap_next;
                  if (n == len) begin
                     if_data_out <= cap_next;
                     if_done_out <= 1'b1;
                     state       <= DONE;
                  end else begin
                     n <= n + 3'd1;
                  end
               end
            end
            LSU_RD: begin
               // cap was cleared at grant, so short loads come out zero-extended.
               cap <= cap_next;
               if (n == len) begin
                  ls_rdata_out <= cap_next;
                  ls_done_out  <= 1'b1;
                  state        <= DONE;
               end else begin
                  n <= n + 3'd1;
               end
            end
            LSU_WR: begin
               if (!io_stall) begin
                  if (n == len - 3'd1) begin
                     ls_done_out <= 1'b1;
                     state       <= DONE;
                  end else begin
                     n <= n + 3'd1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RAM_ARB_AGING_EN
   localparam int AGE_W = $clog2(AGE_LIMIT + 1);
   logic [AGE_W-1:0] age;

   // Count IDLE arbitrations a waiting fetch loses to the LSU; saturate at the limit.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         age <= '0;
      end else if (rdy_in) begin
         if (flush_in || if_grant) begin
            age <= '0;
         end else if (if_req_in && ls_grant && !age_win) begin
            age <= age + AGE_W'(1);
         end
      end
   end

   assign age_win = (age == AGE_W'(AGE_LIMIT));
`else
   assign age_win = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter. It uses a 64 KiB byte RAM (low 16 address bits
// decoded) with 1-cycle read latency, plus a separate reference memory.
// Directed spec scenarios run first, followed by randomized loads, stores and fetches.
module tb_ram_port_arbiter;
   localparam int AGE_LIMIT = 8;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, if_req_in, flush_in, ls_req_in, ls_wr_in, io_buffer_full;
   logic [31:0] if_addr_in, ls_addr_in, ls_wdata_in;
   logic [1:0]  ls_size_in;
   logic        if_done_out, ls_done_out, mem_wr, busy_out;
   logic [31:0] if_data_out, ls_rdata_out, mem_a;
   logic [7:0]  mem_din, mem_dout;

   int tests = 0;
   int fails = 0;

   ram_port_arbiter #(.ADDR_W(32), .AGE_LIMIT(AGE_LIMIT), .IO_HI(2'b11)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
      .if_data_out(if_data_out), .flush_in(flush_in),
      .ls_req_in(ls_req_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
      .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in), .ls_done_out(ls_done_out),
      .ls_rdata_out(ls_rdata_out), .io_buffer_full(io_buffer_full),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Unwritten RAM reads back an address-derived pattern.
   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // ---------------- RAM device (driven by DUT) ----------------
   bit   [7:0]  dev [0:65535];
   logic        bd_we = 1'b0;
   logic [15:0] bd_a  = '0;
   logic [7:0]  bd_d  = '0;
   int          wr_cnt = 0;
   logic [31:0] wr_a [0:1023];
   logic [7:0]  wr_d [0:1023];

   always @(posedge clk_in) begin
      mem_din <= dev[mem_a[15:0]] ^ pat(mem_a[15:0]);
      if (mem_wr) begin
         dev[mem_a[15:0]]     <= mem_dout ^ pat(mem_a[15:0]);
         wr_a[wr_cnt % 1024]  <= mem_a;
         wr_d[wr_cnt % 1024]  <= mem_dout;
         wr_cnt               <= wr_cnt + 1;
      end else if (bd_we) begin
         dev[bd_a] <= bd_d ^ pat(bd_a);
      end
   end

   // ---------------- reference model ----------------
   bit [7:0] ref_mem [0:65535];

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem[a[15:0]] ^ pat(a[15:0]);
   endfunction

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
      logic [31:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         ref_mem[ai[15:0]] = wd[8*i +: 8] ^ pat(ai[15:0]);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_a = a; bd_d = d;
      @(posedge clk_in); #1;
      bd_we = 1'b0;
      ref_mem[a] = d ^ pat(a);
   endtask

   // One LSU transaction; cycle 0 is the grant cycle. Windows select
   // io_buffer_full high / rdy_in low cycles; fl_at pulses flush_in.
   task automatic run_ls(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int io_lo, input int io_hi,
                         input int rdy_lo, input int rdy_hi, input int fl_at,
                         output logic [31:0] rd, output int lat);
      logic [31:0] prev_a;
      logic        prev_frz;
      logic        io_reg;
      lat = -1; rd = '0; prev_a = '0; prev_frz = 1'b0;
      io_reg = (a[17:16] == 2'b11);
      ls_wr_in = wr; ls_size_in = sz; ls_addr_in = a; ls_wdata_in = wd; ls_req_in = 1'b1;
      for (int c = 0; c < 100 && lat < 0; c++) begin
         io_buffer_full = (c >= io_lo && c <= io_hi);
         rdy_in         = !(c >= rdy_lo && c <= rdy_hi);
         flush_in       = (c == fl_at);
         @(negedge clk_in);
         if (!rdy_in) chk("frz_wr", 32'(mem_wr), 32'd0);
         if (!rdy_in && prev_frz) chk("frz_a_held", mem_a, prev_a);
         if (io_buffer_full && io_reg) chk("io_stall_wr", 32'(mem_wr), 32'd0);
         prev_frz = !rdy_in;
         prev_a   = mem_a;
         if (ls_done_out) begin
            lat = c; rd = ls_rdata_out; ls_req_in = 1'b0;
         end
         @(posedge clk_in); #1;
      end
      io_buffer_full = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; ls_req_in = 1'b0;
      chk("ls_done_seen", 32'(lat >= 0), 32'd1);
   endtask

   task automatic run_if(input logic [31:0] a, input int fl_at,
                         output logic [31:0] d, output int lat);
      lat = -1; d = '0;
      if_addr_in = a; if_req_in = 1'b1;
      for (int c = 0; c < 40 && lat < 0; c++) begin
         flush_in = (c == fl_at);
         if (c == fl_at) if_req_in = 1'b0;
         @(negedge clk_in);
         if (mem_wr) chk("fetch_no_wr", 32'(mem_wr), 32'd0);
         if (fl_at >= 0 && c == fl_at + 1) chk("flush_idle", 32'(busy_out), 32'd0);
         if (if_done_out) begin
            lat = c; d = if_data_out; if_req_in = 1'b0;
         end
         @(posedge clk_in); #1;
      end
      flush_in = 1'b0; if_req_in = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input int fl_at,
                          input string tag);
      logic [31:0] rd;
      int lat;
      run_ls(1'b0, sz, a, 32'd0, -1, -1, -1, -1, fl_at, rd, lat);
      chk({tag, "_data"}, rd, ref_load(a, nbytes(sz)));
      chk({tag, "_lat"}, 32'(lat), 32'(nbytes(sz) + 2));
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                           input int io_lo, input int io_hi, input int rdy_lo, input int rdy_hi,
                           input int exp_lat, input string tag);
      logic [31:0] rd, ai;
      int w0, lat, n;
      w0 = wr_cnt; n = nbytes(sz);
      run_ls(1'b1, sz, a, wd, io_lo, io_hi, rdy_lo, rdy_hi, -1, rd, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_nwr"}, 32'(wr_cnt - w0), 32'(n));
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         chk({tag, "_wa"}, wr_a[(w0 + i) % 1024], ai);
         chk({tag, "_wd"}, 32'(wr_d[(w0 + i) % 1024]), 32'(wd[8*i +: 8]));
      end
      ref_store(a, n, wd);
   endtask

   initial begin
      logic [31:0] rd, fd, a, wd;
      logic [1:0]  sz;
      int lat, ls_cyc, if_cyc, n_ls, w0, kind, fl, nd;

      rst_in = 1'b1; rdy_in = 1'b1; if_req_in = 1'b0; flush_in = 1'b0;
      ls_req_in = 1'b0; ls_wr_in = 1'b0; io_buffer_full = 1'b0;
      if_addr_in = '0; ls_addr_in = '0; ls_wdata_in = '0; ls_size_in = '0;
      repeat (3) @(posedge clk_in);
      #1;
      // reset state
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_dout", 32'(mem_dout), 32'd0);
      chk("rst_if_done", 32'(if_done_out), 32'd0);
      chk("rst_ls_done", 32'(ls_done_out), 32'd0);
      chk("rst_if_data", if_data_out, 32'd0);
      chk("rst_ls_rdata", ls_rdata_out, 32'd0);
      rst_in = 1'b0;
      @(posedge clk_in); #1;

      // word load at 0x100 from bytes 11 22 33 44
      poke(16'h0100, 8'h11); poke(16'h0101, 8'h22);
      poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
      run_ls(1'b0, 2'b10, 32'h100, 32'd0, -1, -1, -1, -1, -1, rd, lat);
      chk("wload_data", rd, 32'h4433_2211);
      chk("wload_lat", 32'(lat), 32'd6);

      // half store 0xBEEF to 0x202, then confirm no stray writes
      do_store(32'h202, 2'b01, 32'h0000_BEEF, -1, -1, -1, -1, 3, "hstore");
      w0 = wr_cnt;
      repeat (4) @(posedge clk_in);
      #1;
      chk("hstore_quiet", 32'(wr_cnt - w0), 32'd0);

      // fetch and LSU together: LSU first, fetch granted in the following IDLE
      ls_wr_in = 1'b0; ls_size_in = 2'b00; ls_addr_in = 32'h104; ls_req_in = 1'b1;
      if_addr_in = 32'h100; if_req_in = 1'b1;
      ls_cyc = -1; if_cyc = -1; rd = '0; fd = '0;
      for (int c = 0; c < 60 && if_cyc < 0; c++) begin
         @(negedge clk_in);
         if (ls_done_out) begin ls_cyc = c; rd = ls_rdata_out; ls_req_in = 1'b0; end
         if (if_done_out) begin if_cyc = c; fd = if_data_out; if_req_in = 1'b0; end
         @(posedge clk_in); #1;
      end
      ls_req_in = 1'b0; if_req_in = 1'b0;
      chk("both_ls_cyc", 32'(ls_cyc), 32'd3);
      chk("both_ls_data", rd, ref_load(32'h104, 1));
      chk("both_if_cyc", 32'(if_cyc), 32'd10);
      chk("both_if_data", fd, 32'h4433_2211);

      // IO byte store stalled five cycles by a full buffer; non-IO store ignores it
      do_store(32'h0003_0000, 2'b00, 32'h5A, 1, 5, -1, -1, 7, "io_st");
      do_store(32'h0002_0010, 2'b00, 32'h77, 0, 5, -1, -1, 2, "nonio_st");

      // freeze mid-store; size 11 acts as a word
      do_store(32'h500, 2'b10, 32'hCAFE_F00D, -1, -1, 2, 3, 7, "frz_st");
      do_store(32'h600, 2'b11, 32'h1357_9BDF, -1, -1, -1, -1, 5, "sz3_st");

      // wrap-around and misaligned loads (flush during an LSU op has no effect)
      do_load(32'hFFFF_FFFE, 2'b10, -1, "wrap_ld");
      do_load(32'h103, 2'b01, 2, "mis_ld");
      do_load(32'h600, 2'b11, 3, "sz3_ld");

      // fetch flushed at grant+2, then a normal fetch
      run_if(32'h40, 2, fd, lat);
      chk("flush_no_done", 32'(lat), 32'hFFFF_FFFF);
      run_if(32'h80, -1, fd, lat);
      chk("fetch80_data", fd, ref_load(32'h80, 4));
      chk("fetch80_lat", 32'(lat), 32'd6);

      // randomized traffic against the reference memory
      for (int t = 0; t < 30; t++) begin
         kind = int'($urandom_range(0, 2));
         sz   = 2'($urandom_range(0, 3));
         a    = 32'h1000 + 32'($urandom_range(0, 255));
         wd   = $urandom;
         fl   = int'($urandom_range(0, 5));
         case (kind)
            0: do_load(a, sz, fl, "rnd_ld");
            1: do_store(a, sz, wd, -1, -1, -1, -1, nbytes(sz) + 1, "rnd_st");
            default: begin
               run_if({a[31:2], 2'b00}, -1, fd, lat);
               chk("rnd_if_data", fd, ref_load({a[31:2], 2'b00}, 4));
               chk("rnd_if_lat", 32'(lat), 32'd6);
            end
         endcase
      end

      // back-to-back LSU byte loads with a fetch waiting
      ls_wr_in = 1'b0; ls_size_in = 2'b00; ls_addr_in = 32'h100; ls_req_in = 1'b1;
      if_addr_in = 32'h80; if_req_in = 1'b1;
      n_ls = 0; if_cyc = -1; fd = '0;
      for (int c = 0; c < 150 && if_cyc < 0; c++) begin
         @(negedge clk_in);
         if (ls_done_out) begin
            n_ls++;
            chk("b2b_ls_data", ls_rdata_out, ref_load(32'h100, 1));
         end
         if (if_done_out) begin
            if_cyc = c; fd = if_data_out; if_req_in = 1'b0; ls_req_in = 1'b0;
         end
`ifndef RAM_ARB_AGING_EN
         if (c == 59) ls_req_in = 1'b0;
`endif
         @(posedge clk_in); #1;
      end
      ls_req_in = 1'b0; if_req_in = 1'b0;
      chk("b2b_if_data", fd, ref_load(32'h80, 4));
`ifdef RAM_ARB_AGING_EN
      chk("age_if_granted", 32'(if_cyc >= 0), 32'd1);
      chk("age_bound", 32'(n_ls <= AGE_LIMIT), 32'd1);
`else
      chk("strict_n_ls", 32'(n_ls), 32'd15);
      chk("strict_if_cyc", 32'(if_cyc), 32'd66);
`endif

      // asynchronous reset in the middle of a load
      do_load(32'h100, 2'b10, -1, "pre_rst_ld");
      ls_wr_in = 1'b0; ls_size_in = 2'b10; ls_addr_in = 32'h100; ls_req_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #2;
      chk("mid_busy", 32'(busy_out), 32'd1);
      rst_in = 1'b1;
      #1;
      chk("arst_busy", 32'(busy_out), 32'd0);
      chk("arst_mem_a", mem_a, 32'd0);
      chk("arst_ls_rdata", ls_rdata_out, 32'd0);
      chk("arst_if_data", if_data_out, 32'd0);
      ls_req_in = 1'b0;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      nd = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_in);
         if (ls_done_out || if_done_out) nd++;
         @(posedge clk_in); #1;
      end
      chk("arst_no_done", 32'(nd), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
